// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg : segment bit indices, digit patterns and scan-capture FSM states
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    ST_BLANK   = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_HELD    = 2'd2,
    ST_PUBLISH = 2'd3
  } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ---------------------------------------------------------------------------
// seg7_pattern_decode : exact-match 7-segment pattern to BCD digit decoder
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] digit_o
);

  always_comb begin
    valid_o = 1'b1;
    digit_o = DIGIT_INVALID;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_capture.sv
// ---------------------------------------------------------------------------
// seg7_scan_capture : recovers a 4-digit BCD value from a multiplexed
//                     7-segment bus, one VALID pulse per completed scan frame
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  seg_i,
  input  logic [3:0]  an_i,
  output logic [15:0] bcd_out_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        stale_o
);

  localparam int CNT_W = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  logic [6:0]       seg_q, seg_prev_q;
  logic [3:0]       an_q, an_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  scan_state_e      state_q, state_d;
  logic [3:0][3:0]  digit_q;
  logic [3:0]       seen_q, seen_d;
  logic             ferr_q, ferr_d;
  logic [15:0]      bcd_q;
  logic             err_q;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             stale_q;

  logic             sel_ok;
  logic [1:0]       sel_idx;
  logic             changed;
  logic             capture;
  logic             publish;
  logic             dec_valid;
  logic [3:0]       dec_digit;

  seg7_pattern_decode u_decode (
    .seg_i   (seg_q),
    .valid_o (dec_valid),
    .digit_o (dec_digit)
  );

  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (an_q)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase

    changed = ({seg_q, an_q} != {seg_prev_q, an_prev_q});

    if (!sel_ok || changed) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // The counter saturates at CNT_LAST, so "reaching" it means arriving there
    // from below or from a fresh sample; a saturated dwell never recaptures.
    capture = sel_ok && (cnt_d == CNT_LAST) && (changed || (cnt_q != CNT_LAST));
    publish = (seen_q == 4'hF);

    seen_d = publish ? 4'h0 : seen_q;
    if (capture) begin
      seen_d[sel_idx] = 1'b1;
    end

    ferr_d = publish ? 1'b0 : ferr_q;
    if (capture && !dec_valid) begin
      ferr_d = 1'b1;
    end

    if (publish) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_MAX) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (publish) begin
      state_d = ST_PUBLISH;
    end else if (!sel_ok) begin
      state_d = ST_BLANK;
    end else if (cnt_d == CNT_LAST) begin
      state_d = ST_HELD;
    end else begin
      state_d = ST_SETTLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seg_q      <= '0;
      an_q       <= 4'hF;
      seg_prev_q <= '0;
      an_prev_q  <= 4'hF;
      cnt_q      <= '0;
      state_q    <= ST_BLANK;
      digit_q    <= '0;
      seen_q     <= 4'h0;
      ferr_q     <= 1'b0;
      bcd_q      <= 16'h0000;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      stale_q    <= 1'b0;
    end else begin
      seg_q      <= seg_i;
      an_q       <= an_i;
      seg_prev_q <= seg_q;
      an_prev_q  <= an_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      seen_q     <= seen_d;
      ferr_q     <= ferr_d;
      tmo_q      <= tmo_d;
      stale_q    <= (tmo_d == TMO_MAX);
      if (capture) begin
        digit_q[sel_idx] <= dec_digit;
      end
      if (publish) begin
        bcd_q <= digit_q;
        err_q <= ferr_q;
      end
    end
  end

  assign bcd_out_o = bcd_q;
  assign valid_o   = (state_q == ST_PUBLISH);
  assign err_o     = err_q;
  assign stale_o   = stale_q;

endmodule

`default_nettype wire
